// File: rtl/decode_queue.sv
// Two-wide MIPS32 decode queue: circular buffer of fetched instructions
// with destination decode and dual-issue pairing checks at the head.
module decode_queue #(
  parameter int DEPTH      = 8,
  parameter bit DUAL_ISSUE = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [1:0]                 in_valid,
  input  logic [31:0]                in_pc0,
  input  logic [31:0]                in_pc1,
  input  logic [31:0]                in_inst0,
  input  logic [31:0]                in_inst1,
  output logic                       in_ready,
  output logic [1:0]                 out_valid,
  output logic [31:0]                out_pc0,
  output logic [31:0]                out_pc1,
  output logic [31:0]                out_inst0,
  output logic [31:0]                out_inst1,
  output logic [1:0]                 out_rf_we,
  output logic [4:0]                 out_rf_waddr0,
  output logic [4:0]                 out_rf_waddr1,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic       we;
    logic [4:0] waddr;
    logic       br;
    logic       mem;
    logic       hilo;
    logic       ser;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] w);
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       spec;
    logic       regimm;
    logic       r_alu;
    logic       i_alu;
    logic       link;
    logic [4:0] dst;
    dec_t       d;
    op     = w[31:26];
    fn     = w[5:0];
    rs     = w[25:21];
    rt     = w[20:16];
    rd     = w[15:11];
    spec   = (op == 6'h00);
    regimm = (op == 6'h01);
    r_alu  = spec & (fn inside {6'h00, 6'h02, 6'h03,
                                6'h04, 6'h06, 6'h07,
                                6'h09, 6'h10, 6'h12,
                                [6'h20:6'h27],
                                6'h2a, 6'h2b});
    i_alu  = op inside {[6'h08:6'h0f], 6'h20, 6'h21,
                        6'h23, 6'h24, 6'h25};
    link   = (op == 6'h03) |
             (regimm & (rt inside {5'h10, 5'h11}));
    dst    = 5'd0;
    unique case (1'b1)
      r_alu:   dst = rd;
      i_alu:   dst = rt;
      link:    dst = 5'd31;
      default: dst = 5'd0;
    endcase
    d.we    = (dst != 5'd0);
    d.waddr = dst;
    d.br    = (op inside {[6'h02:6'h07]}) |
              (regimm & (rt inside {5'h00, 5'h01,
                                    5'h10, 5'h11})) |
              (spec & (fn inside {6'h08, 6'h09}));
    d.mem   = op inside {6'h20, 6'h21, 6'h23, 6'h24,
                         6'h25, 6'h28, 6'h29, 6'h2b};
    d.hilo  = spec & (fn inside {[6'h10:6'h13],
                                 [6'h18:6'h1b]});
    d.ser   = (spec & (fn inside {6'h0c, 6'h0d})) |
              ((op == 6'h10) & (rs inside {5'h00, 5'h04})) |
              (w == 32'h4200_0018);
    return d;
  endfunction

  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] head1;
  logic [AW-1:0] tail1;
  logic [1:0]    enq_n;
  logic [1:0]    deq_n;
  dec_t          d0;
  dec_t          d1;
  logic          hazard;

  assign head1    = head + AW'(1);
  assign tail1    = tail + AW'(1);
  assign in_ready = (count <= CW'(DEPTH - 2));

  assign out_pc0   = pc_mem[head];
  assign out_pc1   = pc_mem[head1];
  assign out_inst0 = inst_mem[head];
  assign out_inst1 = inst_mem[head1];

  assign d0 = decode(out_inst0);
  assign d1 = decode(out_inst1);

  // Slot-0 write vs. slot-1 source check ignores whether the field is used.
  assign hazard = d0.br | d1.br |
                  (d0.mem & d1.mem) |
                  (d0.hilo & d1.hilo) |
                  d1.ser |
                  (d0.we & ((d0.waddr == out_inst1[25:21]) |
                            (d0.waddr == out_inst1[20:16])));

  assign out_valid[0] = (count >= CW'(1));
  assign out_valid[1] = DUAL_ISSUE & (count >= CW'(2)) & ~hazard;

  assign out_rf_we[0]  = d0.we & out_valid[0];
  assign out_rf_we[1]  = d1.we & out_valid[1];
  assign out_rf_waddr0 = d0.waddr;
  assign out_rf_waddr1 = d1.waddr;

  always_comb begin
    enq_n = 2'd0;
    deq_n = 2'd0;
    if (in_ready) begin
      unique case (in_valid)
        2'b01:   enq_n = 2'd1;
        2'b11:   enq_n = 2'd2;
        default: enq_n = 2'd0;
      endcase
    end
    if (out_ready)
      deq_n = {1'b0, out_valid[0]} + {1'b0, out_valid[1]};
  end

  always_ff @(posedge clk) begin
    if (enq_n != 2'd0) begin
      pc_mem[tail]   <= in_pc0;
      inst_mem[tail] <= in_inst0;
    end
    if (enq_n == 2'd2) begin
      pc_mem[tail1]   <= in_pc1;
      inst_mem[tail1] <= in_inst1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(deq_n);
      tail  <= tail + AW'(enq_n);
      count <= count + CW'(enq_n) - CW'(deq_n);
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: a dual-issue and a
// single-issue instance share one stimulus stream.
module tb_decode_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [1:0]  in_valid;
  logic [31:0] in_pc0, in_pc1, in_inst0, in_inst1;
  logic        out_ready;

  logic        in_ready, s_in_ready;
  logic [1:0]  out_valid, s_out_valid;
  logic [31:0] out_pc0, out_pc1, out_inst0, out_inst1;
  logic [31:0] s_pc0, s_pc1, s_inst0, s_inst1;
  logic [1:0]  out_rf_we, s_rf_we;
  logic [4:0]  waddr0, waddr1, s_waddr0, s_waddr1;
  logic [3:0]  count, s_count;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  decode_queue #(.DEPTH(8), .DUAL_ISSUE(1'b1)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid),
    .in_pc0(in_pc0), .in_pc1(in_pc1),
    .in_inst0(in_inst0), .in_inst1(in_inst1),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_pc0(out_pc0), .out_pc1(out_pc1),
    .out_inst0(out_inst0), .out_inst1(out_inst1),
    .out_rf_we(out_rf_we),
    .out_rf_waddr0(waddr0), .out_rf_waddr1(waddr1),
    .out_ready(out_ready),
    .count(count)
  );

  decode_queue #(.DEPTH(8), .DUAL_ISSUE(1'b0)) u_single (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid),
    .in_pc0(in_pc0), .in_pc1(in_pc1),
    .in_inst0(in_inst0), .in_inst1(in_inst1),
    .in_ready(s_in_ready),
    .out_valid(s_out_valid),
    .out_pc0(s_pc0), .out_pc1(s_pc1),
    .out_inst0(s_inst0), .out_inst1(s_inst1),
    .out_rf_we(s_rf_we),
    .out_rf_waddr0(s_waddr0), .out_rf_waddr1(s_waddr1),
    .out_ready(out_ready),
    .count(s_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0]  v,
                      input logic [31:0] p0,
                      input logic [31:0] i0,
                      input logic [31:0] p1,
                      input logic [31:0] i1);
    in_valid = v;
    in_pc0   = p0;
    in_inst0 = i0;
    in_pc1   = p1;
    in_inst1 = i1;
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    load(2'b00, 0, 0, 0, 0);
    tick;
    tick;
    rst = 1'b0;

    chk("rst_count", 32'(count), 32'd0);
    chk("rst_oval", 32'(out_valid), 32'd0);
    chk("rst_inrdy", 32'(in_ready), 32'd1);
    chk("rst_we", 32'(out_rf_we), 32'd0);

    // Illegal 10 pattern is dropped.
    load(2'b10, 32'h40, 32'h00221821, 32'h44, 0);
    tick;
    load(2'b00, 0, 0, 0, 0);
    chk("ill_count", 32'(count), 32'd0);

    // Dependent addu pair issues one at a time.
    out_ready = 1'b1;
    load(2'b11, 32'hBFC00000, 32'h00221821,
         32'hBFC00004, 32'h00642821);
    tick;
    load(2'b00, 0, 0, 0, 0);
    chk("dep_oval1", 32'(out_valid), 32'd1);
    chk("dep_wa1", 32'(waddr0), 32'd3);
    tick;
    chk("dep_oval2", 32'(out_valid), 32'd1);
    chk("dep_wa2", 32'(waddr0), 32'd5);
    chk("dep_pc2", out_pc0, 32'hBFC00004);
    tick;
    chk("dep_empty", 32'(count), 32'd0);

    // Independent pair dual-issues and drains in one cycle.
    out_ready = 1'b0;
    load(2'b11, 32'h1000, 32'h00221821,
         32'h1004, 32'h34E60010);
    tick;
    load(2'b00, 0, 0, 0, 0);
    chk("pair_oval", 32'(out_valid), 32'd3);
    chk("pair_we", 32'(out_rf_we), 32'd3);
    chk("pair_wa0", 32'(waddr0), 32'd3);
    chk("pair_wa1", 32'(waddr1), 32'd6);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("pair_count", 32'(count), 32'd0);
    chk("pair_oval0", 32'(out_valid), 32'd0);

    // Fill to DEPTH starting mid-buffer, then drain across wrap.
    for (int k = 0; k < 4; k++) begin
      load(2'b11, 32'h100 + 32'(8 * k), 32'h0,
           32'h104 + 32'(8 * k), 32'h0);
      tick;
    end
    chk("full_count", 32'(count), 32'd8);
    chk("full_inrdy", 32'(in_ready), 32'd0);
    load(2'b11, 32'h200, 32'h0, 32'h204, 32'h0);
    tick;
    load(2'b00, 0, 0, 0, 0);
    chk("full_ignored", 32'(count), 32'd8);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_oval", 32'(out_valid), 32'd3);
      chk("drain_pc0", out_pc0, 32'h100 + 32'(8 * k));
      chk("drain_pc1", out_pc1, 32'h104 + 32'(8 * k));
      tick;
    end
    out_ready = 1'b0;
    chk("drain_count", 32'(count), 32'd0);

    // Flush beats simultaneous enqueue and dequeue.
    for (int k = 0; k < 2; k++) begin
      load(2'b11, 32'h300 + 32'(8 * k), 32'h0,
           32'h304 + 32'(8 * k), 32'h0);
      tick;
    end
    chk("fl_pre", 32'(count), 32'd4);
    flush     = 1'b1;
    out_ready = 1'b1;
    load(2'b11, 32'h400, 32'h0, 32'h404, 32'h0);
    tick;
    flush     = 1'b0;
    out_ready = 1'b0;
    load(2'b00, 0, 0, 0, 0);
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_oval", 32'(out_valid), 32'd0);
    chk("fl_inrdy", 32'(in_ready), 32'd1);

    // Write to $0 and a branch: no pairing, no writes.
    load(2'b11, 32'h500, 32'h00220021,
         32'h504, 32'h10220004);
    tick;
    load(2'b00, 0, 0, 0, 0);
    chk("br_oval", 32'(out_valid), 32'd1);
    chk("br_we", 32'(out_rf_we), 32'd0);
    out_ready = 1'b1;
    tick;
    chk("br_oval2", 32'(out_valid), 32'd1);
    chk("br_pc", out_pc0, 32'h504);
    chk("br_we2", 32'(out_rf_we), 32'd0);
    tick;
    out_ready = 1'b0;
    chk("br_count", 32'(count), 32'd0);

    // Single-issue instance on the independent pair.
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("si_rst", 32'(s_out_valid), 32'd0);
    load(2'b11, 32'h600, 32'h00221821,
         32'h604, 32'h34E60010);
    tick;
    load(2'b00, 0, 0, 0, 0);
    chk("si_oval1", 32'(s_out_valid), 32'd1);
    chk("si_wa1", 32'(s_waddr0), 32'd3);
    out_ready = 1'b1;
    tick;
    chk("si_oval2", 32'(s_out_valid), 32'd1);
    chk("si_wa2", 32'(s_waddr0), 32'd6);
    tick;
    out_ready = 1'b0;
    chk("si_count", 32'(s_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
